// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if: Execute-stage inputs and Memory-stage outputs of the condition/flag unit
// Ports: valid/stall/flush handshake, cond/flag/ALU inputs, decoder controls in;
// cond_out, flags32 {N,Z}, flags10 {C,V}, gated _m controls and retire counters out.
interface cond_flag_unit_if #(parameter int CNT_W = 16);
  logic             valid_e;
  logic             stall_e;
  logic             flush_e;
  logic [3:0]       cond_e;
  logic [1:0]       flag_write_e;
  logic [3:0]       alu_flags;
  logic             cond_ex;
  logic             pcsrc_e;
  logic             regwrite_e;
  logic             memwrite_e;
  logic [3:0]       cond_out;
  logic [1:0]       flags32;
  logic [1:0]       flags10;
  logic             pcsrc_m;
  logic             regwrite_m;
  logic             memwrite_m;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] annul_cnt;
  modport slave (
    input  valid_e, stall_e, flush_e, cond_e, flag_write_e, alu_flags, cond_ex,
           pcsrc_e, regwrite_e, memwrite_e,
    output cond_out, flags32, flags10, pcsrc_m, regwrite_m, memwrite_m, exec_cnt, annul_cnt
  );
  modport master (
    output valid_e, stall_e, flush_e, cond_e, flag_write_e, alu_flags, cond_ex,
           pcsrc_e, regwrite_e, memwrite_e,
    input  cond_out, flags32, flags10, pcsrc_m, regwrite_m, memwrite_m, exec_cnt, annul_cnt
  );
endinterface

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: condition-gated flag registers, Execute->Memory control gating and retire counters
// Ports: clk, rst (sync, active-high), bus (cond_flag_unit_if.slave; CNT_W must match the interface).
module cond_flag_unit #(parameter int CNT_W = 16) (
  input logic            clk,
  input logic            rst,
  cond_flag_unit_if.slave bus
);
  logic advance;
  logic retire;
  assign advance = bus.valid_e & ~bus.stall_e & ~bus.flush_e;
  assign retire = advance & bus.cond_ex;
  assign bus.cond_out = bus.cond_e;
  // A stall freezes everything; otherwise a non-advancing cycle pushes a bubble into Memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.flags32    <= '0;
      bus.flags10    <= '0;
      bus.pcsrc_m    <= 1'b0;
      bus.regwrite_m <= 1'b0;
      bus.memwrite_m <= 1'b0;
      bus.exec_cnt   <= '0;
      bus.annul_cnt  <= '0;
    end else if (!bus.stall_e) begin
      bus.pcsrc_m    <= retire & bus.pcsrc_e;
      bus.regwrite_m <= retire & bus.regwrite_e;
      bus.memwrite_m <= retire & bus.memwrite_e;
      if (retire && bus.flag_write_e[1]) bus.flags32 <= bus.alu_flags[3:2];
      if (retire && bus.flag_write_e[0]) bus.flags10 <= bus.alu_flags[1:0];
      if (retire && bus.exec_cnt != '1) bus.exec_cnt <= bus.exec_cnt + CNT_W'(1);
      if (advance && !bus.cond_ex && bus.annul_cnt != '1) bus.annul_cnt <= bus.annul_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: directed-vector bench for cond_flag_unit with CNT_W=4
module tb_cond_flag_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  cond_flag_unit_if #(.CNT_W(4)) bus ();
  cond_flag_unit #(.CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic s, input logic f, input logic cx,
                       input logic [1:0] fw, input logic [3:0] af,
                       input logic pe, input logic re, input logic me);
    bus.valid_e = v; bus.stall_e = s; bus.flush_e = f; bus.cond_ex = cx;
    bus.flag_write_e = fw; bus.alu_flags = af;
    bus.pcsrc_e = pe; bus.regwrite_e = re; bus.memwrite_e = me;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.cond_e = 4'hA;
    drive(1, 0, 0, 1, 2'b11, 4'hF, 1, 1, 1);
    cycle();
    n_vec++; if (bus.flags32 !== 2'b00) begin n_err++; $display("FAIL reset_flags32 got %b exp 00", bus.flags32); end
    n_vec++; if (bus.flags10 !== 2'b00) begin n_err++; $display("FAIL reset_flags10 got %b exp 00", bus.flags10); end
    n_vec++; if ({bus.pcsrc_m, bus.regwrite_m, bus.memwrite_m} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl got %b exp 000", {bus.pcsrc_m, bus.regwrite_m, bus.memwrite_m}); end
    n_vec++; if (bus.exec_cnt !== 4'h0) begin n_err++; $display("FAIL reset_exec got %h exp 0", bus.exec_cnt); end
    n_vec++; if (bus.annul_cnt !== 4'h0) begin n_err++; $display("FAIL reset_annul got %h exp 0", bus.annul_cnt); end
    n_vec++; if (bus.cond_out !== 4'hA) begin n_err++; $display("FAIL reset_cond_out got %h exp a", bus.cond_out); end
    bus.cond_e = 4'h3;
    #1;
    n_vec++; if (bus.cond_out !== 4'h3) begin n_err++; $display("FAIL comb_cond_out got %h exp 3", bus.cond_out); end
    drive(0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);
    rst = 1'b0;
    cycle();
  endtask
  task automatic test_flag_load();
    drive(1, 0, 0, 1, 2'b11, 4'b0110, 0, 1, 0);
    cycle();
    n_vec++; if (bus.flags32 !== 2'b01) begin n_err++; $display("FAIL load_flags32 got %b exp 01", bus.flags32); end
    n_vec++; if (bus.flags10 !== 2'b10) begin n_err++; $display("FAIL load_flags10 got %b exp 10", bus.flags10); end
    n_vec++; if (bus.exec_cnt !== 4'h1) begin n_err++; $display("FAIL load_exec got %h exp 1", bus.exec_cnt); end
    n_vec++; if (bus.regwrite_m !== 1'b1) begin n_err++; $display("FAIL load_regwrite_m got %b exp 1", bus.regwrite_m); end
  endtask
  task automatic test_annul();
    drive(1, 0, 0, 0, 2'b11, 4'b1001, 0, 1, 1);
    cycle();
    n_vec++; if ({bus.regwrite_m, bus.memwrite_m} !== 2'b00) begin n_err++; $display("FAIL annul_ctrl got %b exp 00", {bus.regwrite_m, bus.memwrite_m}); end
    n_vec++; if ({bus.flags32, bus.flags10} !== 4'b0110) begin n_err++; $display("FAIL annul_flags got %b exp 0110", {bus.flags32, bus.flags10}); end
    n_vec++; if (bus.annul_cnt !== 4'h1) begin n_err++; $display("FAIL annul_cnt got %h exp 1", bus.annul_cnt); end
    n_vec++; if (bus.exec_cnt !== 4'h1) begin n_err++; $display("FAIL annul_exec got %h exp 1", bus.exec_cnt); end
  endtask
  task automatic test_stall();
    drive(1, 0, 0, 1, 2'b00, 4'h0, 0, 1, 0);
    cycle();
    n_vec++; if (bus.regwrite_m !== 1'b1) begin n_err++; $display("FAIL stall_setup_regwrite got %b exp 1", bus.regwrite_m); end
    drive(1, 1, 0, 1, 2'b11, 4'b1001, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_vec++; if (bus.regwrite_m !== 1'b1) begin n_err++; $display("FAIL stall_regwrite_%0d got %b exp 1", i, bus.regwrite_m); end
      n_vec++; if ({bus.flags32, bus.flags10} !== 4'b0110) begin n_err++; $display("FAIL stall_flags_%0d got %b exp 0110", i, {bus.flags32, bus.flags10}); end
      n_vec++; if ({bus.exec_cnt, bus.annul_cnt} !== 8'h21) begin n_err++; $display("FAIL stall_cnt_%0d got %h exp 21", i, {bus.exec_cnt, bus.annul_cnt}); end
    end
    bus.flush_e = 1'b1;
    cycle();
    n_vec++; if (bus.regwrite_m !== 1'b1) begin n_err++; $display("FAIL stall_flush_regwrite got %b exp 1", bus.regwrite_m); end
    n_vec++; if ({bus.exec_cnt, bus.annul_cnt} !== 8'h21) begin n_err++; $display("FAIL stall_flush_cnt got %h exp 21", {bus.exec_cnt, bus.annul_cnt}); end
  endtask
  task automatic test_flush();
    drive(1, 0, 1, 1, 2'b10, 4'b1000, 1, 0, 0);
    cycle();
    n_vec++; if ({bus.pcsrc_m, bus.regwrite_m} !== 2'b00) begin n_err++; $display("FAIL flush_ctrl got %b exp 00", {bus.pcsrc_m, bus.regwrite_m}); end
    n_vec++; if (bus.flags32 !== 2'b01) begin n_err++; $display("FAIL flush_flags32 got %b exp 01", bus.flags32); end
    n_vec++; if ({bus.exec_cnt, bus.annul_cnt} !== 8'h21) begin n_err++; $display("FAIL flush_cnt got %h exp 21", {bus.exec_cnt, bus.annul_cnt}); end
  endtask
  task automatic test_partial_write();
    drive(1, 0, 0, 1, 2'b01, 4'b1101, 1, 0, 1);
    cycle();
    n_vec++; if ({bus.flags32, bus.flags10} !== 4'b0101) begin n_err++; $display("FAIL cv_only_flags got %b exp 0101", {bus.flags32, bus.flags10}); end
    n_vec++; if ({bus.pcsrc_m, bus.regwrite_m, bus.memwrite_m} !== 3'b101) begin n_err++; $display("FAIL cv_only_ctrl got %b exp 101", {bus.pcsrc_m, bus.regwrite_m, bus.memwrite_m}); end
    drive(1, 0, 0, 1, 2'b10, 4'b1011, 0, 0, 0);
    cycle();
    n_vec++; if ({bus.flags32, bus.flags10} !== 4'b1001) begin n_err++; $display("FAIL nz_only_flags got %b exp 1001", {bus.flags32, bus.flags10}); end
    n_vec++; if (bus.exec_cnt !== 4'h4) begin n_err++; $display("FAIL partial_exec got %h exp 4", bus.exec_cnt); end
    drive(0, 0, 0, 1, 2'b11, 4'h0, 1, 1, 1);
    cycle();
    n_vec++; if ({bus.pcsrc_m, bus.regwrite_m, bus.memwrite_m} !== 3'b000) begin n_err++; $display("FAIL bubble_ctrl got %b exp 000", {bus.pcsrc_m, bus.regwrite_m, bus.memwrite_m}); end
    n_vec++; if ({bus.flags32, bus.flags10, bus.exec_cnt} !== 8'h94) begin n_err++; $display("FAIL bubble_state got %h exp 94", {bus.flags32, bus.flags10, bus.exec_cnt}); end
  endtask
  task automatic test_saturation();
    drive(1, 0, 0, 1, 2'b00, 4'h0, 0, 0, 0);
    for (int i = 0; i < 11; i++) cycle();
    n_vec++; if (bus.exec_cnt !== 4'hF) begin n_err++; $display("FAIL exec_reach_max got %h exp f", bus.exec_cnt); end
    for (int i = 0; i < 9; i++) cycle();
    n_vec++; if (bus.exec_cnt !== 4'hF) begin n_err++; $display("FAIL exec_saturate got %h exp f", bus.exec_cnt); end
    bus.cond_ex = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    n_vec++; if (bus.annul_cnt !== 4'hF) begin n_err++; $display("FAIL annul_saturate got %h exp f", bus.annul_cnt); end
    n_vec++; if (bus.exec_cnt !== 4'hF) begin n_err++; $display("FAIL exec_hold got %h exp f", bus.exec_cnt); end
  endtask
  task automatic test_reset_mid();
    drive(1, 0, 0, 1, 2'b11, 4'hF, 1, 1, 1);
    rst = 1'b1;
    cycle();
    n_vec++; if ({bus.flags32, bus.flags10} !== 4'b0000) begin n_err++; $display("FAIL rst_mid_flags got %b exp 0000", {bus.flags32, bus.flags10}); end
    n_vec++; if ({bus.pcsrc_m, bus.regwrite_m, bus.memwrite_m} !== 3'b000) begin n_err++; $display("FAIL rst_mid_ctrl got %b exp 000", {bus.pcsrc_m, bus.regwrite_m, bus.memwrite_m}); end
    n_vec++; if ({bus.exec_cnt, bus.annul_cnt} !== 8'h00) begin n_err++; $display("FAIL rst_mid_cnt got %h exp 00", {bus.exec_cnt, bus.annul_cnt}); end
    rst = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);
    cycle();
  endtask
  initial begin
    bus.cond_e = 4'h0;
    drive(0, 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);
    test_reset();
    test_flag_load();
    test_annul();
    test_stall();
    test_flush();
    test_partial_write();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cond_flag_unit.md
COND_FLAG_UNIT -- requirements
Module: cond_flag_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the executed and annulled instruction counters.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port valid_e, input, 1: an instruction occupies the Execute stage.
REQ-005 SHALL have port stall_e, input, 1: hold the Execute stage; no state change except reset.
REQ-006 SHALL have port flush_e, input, 1: kill the Execute instruction; a bubble goes to Memory.
REQ-007 SHALL have port cond_e, input, 4: condition field of the Execute instruction.
REQ-008 SHALL have port flag_write_e, input, 2: bit1 updates {N,Z}; bit0 updates {C,V}.
REQ-009 SHALL have port alu_flags, input, 4: ALU result flags {N,Z,C,V}.
REQ-010 SHALL have port cond_ex, input, 1: condition-passed result returned by the condition checker.
REQ-011 SHALL have ports pcsrc_e, regwrite_e, memwrite_e, input, 1 each: ungated decoder controls.
REQ-012 SHALL have port cond_out, output, 4: cond_e passed through combinationally to the condition checker.
REQ-013 SHALL have port flags32, output, 2: registered {N,Z}; bit1 is N, bit0 is Z.
REQ-014 SHALL have port flags10, output, 2: registered {C,V}; bit1 is C, bit0 is V.
REQ-015 SHALL have ports pcsrc_m, regwrite_m, memwrite_m, output, 1 each: gated controls registered into the Memory stage.
REQ-016 SHALL have ports exec_cnt and annul_cnt, output, CNT_W each: counts of retired executed and annulled instructions.

Function
REQ-017 SHALL define advance = valid_e & ~stall_e & ~flush_e, evaluated each cycle.
REQ-018 SHALL drive cond_out = cond_e with zero latency and no registering.
REQ-019 SHALL, on an edge with advance=1, cond_ex=1 and flag_write_e[1]=1, load flags32 <= alu_flags[3:2].
REQ-020 SHALL, on an edge with advance=1, cond_ex=1 and flag_write_e[0]=1, load flags10 <= alu_flags[1:0].
REQ-021 SHALL hold both flag registers unchanged in every other case, including cond_ex=0, stall_e=1 and flush_e=1.
REQ-022 SHALL make the flag update visible on flags32/flags10 one cycle after the writing edge, with no bypass; the next instruction evaluates against the updated flags.
REQ-023 SHALL, when advance=1, register pcsrc_m, regwrite_m and memwrite_m as the matching _e signal AND cond_ex.
REQ-024 SHALL, when stall_e=1 (and rst=0), hold pcsrc_m, regwrite_m and memwrite_m at their current values.
REQ-025 SHALL, when stall_e=0 and (flush_e=1 or valid_e=0), load 0 into pcsrc_m, regwrite_m and memwrite_m.
REQ-026 SHALL give flush_e priority over valid_e; a stall with a flush in the same cycle SHALL behave as a stall.
REQ-027 SHALL increment exec_cnt by 1 on each edge with advance=1 and cond_ex=1.
REQ-028 SHALL increment annul_cnt by 1 on each edge with advance=1 and cond_ex=0.
REQ-029 SHALL saturate both counters at 2^CNT_W-1 and never wrap.
REQ-030 SHALL treat a cond_ex of X or unused-code input as a pass-through of the checker result; no internal decoding of cond_e.

Reset
REQ-031 SHALL, on an edge with rst=1, set flags32=2'b00, flags10=2'b00, pcsrc_m=regwrite_m=memwrite_m=0, exec_cnt=0 and annul_cnt=0.
REQ-032 SHALL give rst priority over stall_e, flush_e and advance; reset mid-instruction discards that instruction with no flag or counter effect.
REQ-033 SHALL keep cond_out combinational during reset, still equal to cond_e.

Verification
REQ-034 Reset then valid_e=1, cond_ex=1, flag_write_e=2'b11, alu_flags=4'b0110 -> next cycle flags32=2'b01, flags10=2'b10, exec_cnt=1.
REQ-035 Drive regwrite_e=1, memwrite_e=1, cond_ex=0, advance=1 -> regwrite_m=0, memwrite_m=0, flags unchanged, annul_cnt incremented by 1.
REQ-036 Hold stall_e=1 for 3 cycles with regwrite_m=1 and flag_write_e=2'b11 -> regwrite_m stays 1; flags and counters unchanged.
REQ-037 Drive flush_e=1 with valid_e=1, cond_ex=1, pcsrc_e=1, flag_write_e=2'b10 -> pcsrc_m=0; flags32 unchanged; counters unchanged.
REQ-038 With CNT_W=4, retire 20 passing instructions -> exec_cnt=4'hF, held at that value.
REQ-039 Assert rst in the same cycle as advance=1, flag_write_e=2'b11 -> all outputs zero next cycle; no flag load.
